// File: rtl/fnd_scan_reader.sv
// Read-back monitor for the multiplexed 4-digit FND bus: debounces each
// digit-select/segment pair, decodes it to BCD and publishes whole frames.
module fnd_scan_reader #(
    parameter int STABLE_CNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  fnd_com,
    input  logic [7:0]  fnd_data,
    output logic [15:0] digit_bcd,
    output logic        frame_valid,
    output logic        frame_err
);

    localparam logic [7:0] RUN_MAX = 8'(STABLE_CNT);
    localparam logic [7:0] RUN_PRE = 8'(STABLE_CNT - 1);

    // {err, code}: err set when the segment pattern is not a known glyph
    function automatic logic [4:0] seg_decode(input logic [7:0] seg);
        logic [4:0] r;
        case (seg)
            8'hC0:   r = 5'h00;
            8'hF9:   r = 5'h01;
            8'hA4:   r = 5'h02;
            8'hB0:   r = 5'h03;
            8'h99:   r = 5'h04;
            8'h92:   r = 5'h05;
            8'h82:   r = 5'h06;
            8'hF8:   r = 5'h07;
            8'h80:   r = 5'h08;
            8'h90:   r = 5'h09;
            8'hFF:   r = 5'h0E;
            8'h7F:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    function automatic logic sel_valid(input logic [3:0] com);
        logic r;
        case (com)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] sel_index(input logic [3:0] com);
        logic [1:0] r;
        case (com)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            4'b0111: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    logic [3:0]  com_q, com_d, prev_com_q, prev_com_d;
    logic [7:0]  data_q, data_d, prev_data_q, prev_data_d;
    logic [7:0]  run_q, run_d;
    logic        acc_q, acc_d;
    logic [1:0]  acc_idx_q, acc_idx_d;
    logic [3:0]  acc_code_q, acc_code_d;
    logic        acc_err_q, acc_err_d;
    logic [15:0] staging_q, staging_d;
    logic [3:0]  seen_q, seen_d;
    logic [3:0]  err_q, err_d;
    logic [15:0] digit_bcd_q, digit_bcd_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_err_q, frame_err_d;

    logic        valid_s;
    logic        same_s;
    logic [4:0]  dec_s;
    logic [3:0]  seen_nxt_s;
    logic [3:0]  err_nxt_s;

    // Sampling, run counting and acceptance of a debounced digit
    always_comb begin
        com_d       = fnd_com;
        data_d      = fnd_data;
        prev_com_d  = com_q;
        prev_data_d = data_q;
        valid_s     = sel_valid(com_q);
        same_s      = (com_q == prev_com_q) && (data_q == prev_data_q);
        dec_s       = seg_decode(data_q);
        if (!valid_s) begin
            run_d = 8'd0;
        end else if (same_s) begin
            run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + 8'd1;
        end else begin
            run_d = 8'd1;
        end
        // Accept only on the transition into RUN_MAX so a long hold fires once
        acc_d      = valid_s && same_s && (run_q == RUN_PRE);
        acc_idx_d  = sel_index(com_q);
        acc_code_d = dec_s[3:0];
        acc_err_d  = dec_s[4];
    end

    // Staging of accepted digits and frame publication
    always_comb begin
        staging_d     = staging_q;
        seen_d        = seen_q;
        err_d         = err_q;
        digit_bcd_d   = digit_bcd_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        seen_nxt_s    = seen_q | (4'b0001 << acc_idx_q);
        err_nxt_s     = err_q;
        err_nxt_s[acc_idx_q] = acc_err_q;
        if (acc_q) begin
            staging_d[{acc_idx_q, 2'b00} +: 4] = acc_code_q;
            if (seen_nxt_s == 4'b1111) begin
                digit_bcd_d   = staging_d;
                frame_valid_d = 1'b1;
                frame_err_d   = |err_nxt_s;
                seen_d        = 4'b0000;
                err_d         = 4'b0000;
            end else begin
                seen_d = seen_nxt_s;
                err_d  = err_nxt_s;
            end
        end else begin
            seen_d = seen_q;
            err_d  = err_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            com_q         <= 4'h0;
            data_q        <= 8'h00;
            prev_com_q    <= 4'h0;
            prev_data_q   <= 8'h00;
            run_q         <= 8'd0;
            acc_q         <= 1'b0;
            acc_idx_q     <= 2'd0;
            acc_code_q    <= 4'h0;
            acc_err_q     <= 1'b0;
            staging_q     <= 16'h0000;
            seen_q        <= 4'h0;
            err_q         <= 4'h0;
            digit_bcd_q   <= 16'h0000;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            com_q         <= com_d;
            data_q        <= data_d;
            prev_com_q    <= prev_com_d;
            prev_data_q   <= prev_data_d;
            run_q         <= run_d;
            acc_q         <= acc_d;
            acc_idx_q     <= acc_idx_d;
            acc_code_q    <= acc_code_d;
            acc_err_q     <= acc_err_d;
            staging_q     <= staging_d;
            seen_q        <= seen_d;
            err_q         <= err_d;
            digit_bcd_q   <= digit_bcd_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign digit_bcd   = digit_bcd_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

endmodule
